// File: rtl/cr_sync_edge_filter_if.sv
// Signal bundle between a cr_sync_edge_filter and its user logic.
// CR_SYNC_EDGE_FALL_CNT_EN adds the falling-edge counter and sticky flag.
`timescale 1ns/1ps
interface cr_sync_edge_filter_if #(
  parameter int CNT_W = 8
);
  logic             sync_in;
  logic             clr_cnt;
  logic             clr_sticky;
  logic             filt_level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] edge_cnt;
  logic             cnt_sat;
  logic             sticky_rise;
`ifdef CR_SYNC_EDGE_FALL_CNT_EN
  logic [CNT_W-1:0] fall_cnt;
  logic             sticky_fall;
`endif

  modport master (
    output sync_in, clr_cnt, clr_sticky,
    input  filt_level, rise_pulse, fall_pulse, edge_cnt, cnt_sat, sticky_rise
`ifdef CR_SYNC_EDGE_FALL_CNT_EN
    , input fall_cnt, sticky_fall
`endif
  );

  modport slave (
    input  sync_in, clr_cnt, clr_sticky,
    output filt_level, rise_pulse, fall_pulse, edge_cnt, cnt_sat, sticky_rise
`ifdef CR_SYNC_EDGE_FALL_CNT_EN
    , output fall_cnt, sticky_fall
`endif
  );
endinterface

// File: rtl/cr_sync_edge_filter.sv
// Deglitches a synchronized level, emits rise/fall pulses, counts rises.
// Optional CR_SYNC_EDGE_FALL_CNT_EN adds a falling-edge counter and sticky flag.
`timescale 1ns/1ps
module cr_sync_edge_filter #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cr_sync_edge_filter_if.slave  bus
);
  localparam int SW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    QUAL_HI   = 2'd1,
    HI_STABLE = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
  logic             filt_level_q, filt_level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sticky_rise_q, sticky_rise_d;
  logic             qual_done_s;

  // Clear takes effect before the increment; the count holds at all-ones.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic clr, input logic inc);
    logic [CNT_W-1:0] base;
    if (clr) base = '0;
    else     base = cnt;
    if (inc && (base != CNT_MAX)) next_cnt = base + CNT_W'(1'b1);
    else                          next_cnt = base;
  endfunction

  function automatic logic next_sticky(input logic q, input logic clr, input logic set);
    next_sticky = set | (q & ~clr);
  endfunction

  assign qual_done_s = ((32'(stab_cnt_q) + 32'd1) == 32'(FILTER_CYCLES));

  // Stability filter next-state and pulse decode.
  always_comb begin
    state_d      = state_q;
    stab_cnt_d   = stab_cnt_q;
    filt_level_d = filt_level_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    case (state_q)
      LO_STABLE: begin
        if (bus.sync_in && (FILTER_CYCLES == 1)) begin
          state_d      = HI_STABLE;
          stab_cnt_d   = '0;
          filt_level_d = 1'b1;
          rise_d       = 1'b1;
        end else if (bus.sync_in) begin
          state_d    = QUAL_HI;
          stab_cnt_d = SW'(1'b1);
        end else begin
          stab_cnt_d = '0;
        end
      end
      QUAL_HI: begin
        if (!bus.sync_in) begin
          state_d    = LO_STABLE;
          stab_cnt_d = '0;
        end else if (qual_done_s) begin
          state_d      = HI_STABLE;
          stab_cnt_d   = '0;
          filt_level_d = 1'b1;
          rise_d       = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1'b1);
        end
      end
      HI_STABLE: begin
        if (!bus.sync_in && (FILTER_CYCLES == 1)) begin
          state_d      = LO_STABLE;
          stab_cnt_d   = '0;
          filt_level_d = 1'b0;
          fall_d       = 1'b1;
        end else if (!bus.sync_in) begin
          state_d    = QUAL_LO;
          stab_cnt_d = SW'(1'b1);
        end else begin
          stab_cnt_d = '0;
        end
      end
      QUAL_LO: begin
        if (bus.sync_in) begin
          state_d    = HI_STABLE;
          stab_cnt_d = '0;
        end else if (qual_done_s) begin
          state_d      = LO_STABLE;
          stab_cnt_d   = '0;
          filt_level_d = 1'b0;
          fall_d       = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1'b1);
        end
      end
      default: begin
        state_d      = LO_STABLE;
        stab_cnt_d   = '0;
        filt_level_d = 1'b0;
      end
    endcase
  end

  assign edge_cnt_d    = next_cnt(edge_cnt_q, bus.clr_cnt, rise_d);
  assign sticky_rise_d = next_sticky(sticky_rise_q, bus.clr_sticky, rise_d);

`ifdef CR_SYNC_EDGE_FALL_CNT_EN
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             sticky_fall_q, sticky_fall_d;

  assign fall_cnt_d    = next_cnt(fall_cnt_q, bus.clr_cnt, fall_d);
  assign sticky_fall_d = next_sticky(sticky_fall_q, bus.clr_sticky, fall_d);

  // Falling-edge status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_cnt_q    <= '0;
      sticky_fall_q <= 1'b0;
    end else begin
      fall_cnt_q    <= fall_cnt_d;
      sticky_fall_q <= sticky_fall_d;
    end
  end

  assign bus.fall_cnt    = fall_cnt_q;
  assign bus.sticky_fall = sticky_fall_q;
`endif

  // Filter state, pulses and rising-edge status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LO_STABLE;
      stab_cnt_q    <= '0;
      filt_level_q  <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      edge_cnt_q    <= '0;
      sticky_rise_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      filt_level_q  <= filt_level_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      edge_cnt_q    <= edge_cnt_d;
      sticky_rise_q <= sticky_rise_d;
    end
  end

  assign bus.filt_level  = filt_level_q;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.edge_cnt    = edge_cnt_q;
  assign bus.cnt_sat     = (edge_cnt_q == CNT_MAX);
  assign bus.sticky_rise = sticky_rise_q;
endmodule

// File: tb/tb_cr_sync_edge_filter.sv
// Directed bench: F=4/CNT_W=8, F=2/CNT_W=2 and F=1/CNT_W=8 instances on one clock.
`timescale 1ns/1ps
module tb_cr_sync_edge_filter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cr_sync_edge_filter_if #(.CNT_W(8)) if_a ();
  cr_sync_edge_filter_if #(.CNT_W(2)) if_b ();
  cr_sync_edge_filter_if #(.CNT_W(8)) if_c ();

  cr_sync_edge_filter #(.FILTER_CYCLES(4), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  cr_sync_edge_filter #(.FILTER_CYCLES(2), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  cr_sync_edge_filter #(.FILTER_CYCLES(1), .CNT_W(8)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       s, cc, cs;
    logic       f, r, fl;
    logic [7:0] cnt;
    logic       st;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, cc, cs, f, r, fl, input logic [7:0] cnt,
                     input logic st, input int reps);
    vec_t v;
    v = '{s: s, cc: cc, cs: cs, f: f, r: r, fl: fl, cnt: cnt, st: st};
    for (int i = 0; i < reps; i++) vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    if_a.sync_in = 1'b0; if_a.clr_cnt = 1'b0; if_a.clr_sticky = 1'b0;
    if_b.sync_in = 1'b0; if_b.clr_cnt = 1'b0; if_b.clr_sticky = 1'b0;
    if_c.sync_in = 1'b0; if_c.clr_cnt = 1'b0; if_c.clr_sticky = 1'b0;
    tick(); tick();
    check("rst.a.filt", 32'(if_a.filt_level), 32'd0);
    check("rst.a.rise", 32'(if_a.rise_pulse), 32'd0);
    check("rst.a.fall", 32'(if_a.fall_pulse), 32'd0);
    check("rst.a.cnt",  32'(if_a.edge_cnt),   32'd0);
    check("rst.a.sat",  32'(if_a.cnt_sat),    32'd0);
    check("rst.a.stk",  32'(if_a.sticky_rise), 32'd0);
    check("rst.b.cnt",  32'(if_b.edge_cnt),   32'd0);
    check("rst.c.filt", 32'(if_c.filt_level), 32'd0);
    rst = 1'b0;

    // s cc cs | filt rise fall cnt sticky | reps
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 6);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 2);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 3);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 3);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1);

    foreach (vq[i]) begin
      if_a.sync_in = vq[i].s; if_a.clr_cnt = vq[i].cc; if_a.clr_sticky = vq[i].cs;
      tick();
      check($sformatf("v%0d.filt", i), 32'(if_a.filt_level),  32'(vq[i].f));
      check($sformatf("v%0d.rise", i), 32'(if_a.rise_pulse),  32'(vq[i].r));
      check($sformatf("v%0d.fall", i), 32'(if_a.fall_pulse),  32'(vq[i].fl));
      check($sformatf("v%0d.cnt", i),  32'(if_a.edge_cnt),    32'(vq[i].cnt));
      check($sformatf("v%0d.stk", i),  32'(if_a.sticky_rise), 32'(vq[i].st));
    end
    if_a.clr_cnt = 1'b0; if_a.clr_sticky = 1'b0;

    // Reset from HI_STABLE, then reset in the middle of a rise qualification.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2.filt", 32'(if_a.filt_level), 32'd0);
    if_a.sync_in = 1'b0; tick();
    if_a.sync_in = 1'b1; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst3.rise", 32'(if_a.rise_pulse), 32'd0);
    check("rst3.filt", 32'(if_a.filt_level), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rq%0d.rise", k), 32'(if_a.rise_pulse), 32'(k == 3));
      check($sformatf("rq%0d.filt", k), 32'(if_a.filt_level), 32'(k >= 3));
    end
    check("rq.cnt", 32'(if_a.edge_cnt), 32'd1);

    // Saturation on the 2-bit counter, F=2.
    for (int k = 1; k <= 5; k++) begin
      if_b.sync_in = 1'b1; tick();
      check($sformatf("sat%0d.pre", k), 32'(if_b.rise_pulse), 32'd0);
      tick();
      check($sformatf("sat%0d.rise", k), 32'(if_b.rise_pulse), 32'd1);
      check($sformatf("sat%0d.cnt", k),  32'(if_b.edge_cnt),   32'((k > 3) ? 3 : k));
      check($sformatf("sat%0d.sat", k),  32'(if_b.cnt_sat),    32'(k >= 3));
      tick();
      if_b.sync_in = 1'b0; tick(); tick(); tick();
      check($sformatf("sat%0d.fall", k), 32'(if_b.filt_level), 32'd0);
    end

    // F=1: every change of sync_in is a qualified edge one cycle later.
    for (int p = 0; p < 4; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        for (int c = 0; c < 3; c++) begin
          if_c.sync_in = (ph == 0);
          tick();
          check($sformatf("f1.%0d.%0d.%0d.rise", p, ph, c), 32'(if_c.rise_pulse), 32'(ph == 0 && c == 0));
          check($sformatf("f1.%0d.%0d.%0d.fall", p, ph, c), 32'(if_c.fall_pulse), 32'(ph == 1 && c == 0));
          check($sformatf("f1.%0d.%0d.%0d.filt", p, ph, c), 32'(if_c.filt_level), 32'(ph == 0));
        end
      end
    end
    check("f1.cnt", 32'(if_c.edge_cnt),    32'd4);
    check("f1.stk", 32'(if_c.sticky_rise), 32'd1);
`ifdef CR_SYNC_EDGE_FALL_CNT_EN
    check("f1.fcnt", 32'(if_c.fall_cnt),    32'd4);
    check("f1.fstk", 32'(if_c.sticky_fall), 32'd1);
    if_c.clr_cnt = 1'b1; if_c.clr_sticky = 1'b1; tick();
    if_c.clr_cnt = 1'b0; if_c.clr_sticky = 1'b0;
    check("f1.fcnt.clr", 32'(if_c.fall_cnt),    32'd0);
    check("f1.fstk.clr", 32'(if_c.sticky_fall), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
